attn_seq: RTL and testbench

Instruction sequencer that drives the core's 17-bit `inst` word and its `mem_in` bus, replacing the hand-written testbench stimulus. On `start` it takes Q and K vectors from a valid/ready host stream into qmem/kmem. It then loads K into the MAC array, runs Q through it, and drains the output FIFO into psum memory. It sits directly above the core and is the only writer of its `inst` and `mem_in` ports.

---
 rtl/attn_seq_pkg.sv | 40 ++++
 rtl/attn_seq_drain.sv | 78 +++++++
 rtl/attn_seq.sv | 198 +++++++++++++++++++
 tb/tb_attn_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/attn_seq_pkg.sv
// rtl/attn_seq_pkg.sv - state encoding, inst word layout and helpers shared by attn_seq
package attn_seq_pkg;

    localparam int INST_W          = 17;
    localparam int INST_OFIFO_RD   = 16;
    localparam int INST_QK_ADD_LSB = 12;
    localparam int INST_P_ADD_LSB  = 8;
    localparam int INST_ADD_W      = 4;
    localparam int INST_EXEC       = 7;
    localparam int INST_KLOAD      = 6;
    localparam int INST_QMEM_RD    = 5;
    localparam int INST_QMEM_WR    = 4;
    localparam int INST_KMEM_RD    = 3;
    localparam int INST_KMEM_WR    = 2;
    localparam int INST_PMEM_RD    = 1;
    localparam int INST_PMEM_WR    = 0;

    // Five bits so a 16-entry phase reaches its terminal count without wrapping.
    localparam int CNT_W  = 5;
    localparam int WDOG_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_Q,
        S_LOAD_K,
        S_KLOAD,
        S_KGAP,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic logic [INST_W-1:0] inst_qk(input logic [INST_ADD_W-1:0] add);
        logic [INST_W-1:0] w;
        w = '0;
        w[INST_QK_ADD_LSB +: INST_ADD_W] = add;
        return w;
    endfunction

endpackage

// File: rtl/attn_seq_drain.sv
// rtl/attn_seq_drain.sv - output FIFO to psum memory drain: rd->wr pipeline, row count, watchdog
// Watchdog present only when ATTN_SEQ_WDOG_EN is defined; otherwise timeout is tied low.
module attn_seq_drain
    import attn_seq_pkg::*;
#(
    parameter int NQ = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  ofifo_valid,
    output logic                  rd,
    output logic                  wr,
    output logic [INST_ADD_W-1:0] pmem_add,
    output logic                  drain_done,
    output logic                  timeout
);

    localparam logic [CNT_W-1:0] NQ_C    = CNT_W'(NQ);
    localparam logic [CNT_W-1:0] NQ_LAST = CNT_W'(NQ - 1);

    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_pend_q, wr_pend_d;

    assign rd         = en && ofifo_valid && (rd_cnt_q != NQ_C);
    assign wr         = wr_pend_q;
    assign pmem_add   = wr_cnt_q[INST_ADD_W-1:0];
    assign drain_done = wr_pend_q && (wr_cnt_q == NQ_LAST);

    // Every read is answered by exactly one psum write on the following cycle.
    always_comb begin
        rd_cnt_d  = '0;
        wr_cnt_d  = '0;
        wr_pend_d = 1'b0;
        if (en) begin
            rd_cnt_d  = rd ? rd_cnt_q + CNT_W'(1) : rd_cnt_q;
            wr_cnt_d  = wr_pend_q ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;
            wr_pend_d = rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            wr_pend_q <= 1'b0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_pend_q <= wr_pend_d;
        end
    end

`ifdef ATTN_SEQ_WDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = '0;
        if (en && !rd) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign timeout = en && !rd && (wdog_q == '1);
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/attn_seq.sv
// rtl/attn_seq.sv - attention core instruction sequencer: host load, kernel load, execute, drain
// Optional DRAIN watchdog and sticky err enabled by defining ATTN_SEQ_WDOG_EN.
module attn_seq
    import attn_seq_pkg::*;
#(
    parameter int BW   = 8,
    parameter int PR   = 16,
    parameter int COL  = 8,
    parameter int NQ   = 8,
    parameter int NK   = 8,
    parameter int KGAP = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PR*BW-1:0]   in_data,
    input  logic               ofifo_valid,
    output logic [INST_W-1:0]  inst,
    output logic [PR*BW-1:0]   mem_in,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [CNT_W-1:0] NQ_C      = CNT_W'(NQ);
    localparam logic [CNT_W-1:0] NK_C      = CNT_W'(NK);
    localparam logic [CNT_W-1:0] NQ_LAST   = CNT_W'(NQ - 1);
    localparam logic [CNT_W-1:0] NK_LAST   = CNT_W'(NK - 1);
    localparam logic [CNT_W-1:0] KGAP_LAST = CNT_W'(KGAP - 1);

    // COL only shapes the core's array; the sequencer never addresses columns.
    if (COL < 1) begin : g_col_unused
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [PR*BW-1:0]    mem_in_q, mem_in_d;

    logic                  drain_rd;
    logic                  drain_wr;
    logic [INST_ADD_W-1:0] drain_add;
    logic                  drain_done;
    logic                  timeout;

    assign in_ready = (state_q == S_LOAD_Q) || (state_q == S_LOAD_K);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign inst     = inst_q;
    assign mem_in   = mem_in_q;

    attn_seq_drain #(
        .NQ (NQ)
    ) u_drain (
        .clk         (clk),
        .reset       (reset),
        .en          (state_q == S_DRAIN),
        .ofifo_valid (ofifo_valid),
        .rd          (drain_rd),
        .wr          (drain_wr),
        .pmem_add    (drain_add),
        .drain_done  (drain_done),
        .timeout     (timeout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inst_d   = '0;
        mem_in_d = mem_in_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_Q;
                    cnt_d   = '0;
                end
            end
            S_LOAD_Q: begin
                if (in_valid) begin
                    mem_in_d             = in_data;
                    inst_d               = inst_qk(cnt_q[INST_ADD_W-1:0]);
                    inst_d[INST_QMEM_WR] = 1'b1;
                    if (cnt_q == NQ_LAST) begin
                        state_d = S_LOAD_K;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_K: begin
                if (in_valid) begin
                    mem_in_d             = in_data;
                    inst_d               = inst_qk(cnt_q[INST_ADD_W-1:0]);
                    inst_d[INST_KMEM_WR] = 1'b1;
                    if (cnt_q == NK_LAST) begin
                        state_d = S_KLOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_KLOAD: begin
                // The extra cycle keeps kernel-load high across the kmem read latency.
                if (cnt_q != NK_C) begin
                    inst_d               = inst_qk(cnt_q[INST_ADD_W-1:0]);
                    inst_d[INST_KMEM_RD] = 1'b1;
                end
                inst_d[INST_KLOAD] = 1'b1;
                if (cnt_q == NK_C) begin
                    state_d = (KGAP == 0) ? S_EXEC : S_KGAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_KGAP: begin
                if (cnt_q == KGAP_LAST) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: begin
                if (cnt_q != NQ_C) begin
                    inst_d               = inst_qk(cnt_q[INST_ADD_W-1:0]);
                    inst_d[INST_QMEM_RD] = 1'b1;
                end
                inst_d[INST_EXEC] = (cnt_q != '0);
                if (cnt_q == NQ_C) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                inst_d[INST_OFIFO_RD]                    = drain_rd;
                inst_d[INST_PMEM_WR]                     = drain_wr;
                inst_d[INST_P_ADD_LSB +: INST_ADD_W]     = drain_wr ? drain_add : '0;
                if (drain_done || timeout) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            inst_q   <= '0;
            mem_in_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inst_q   <= inst_d;
            mem_in_q <= mem_in_d;
        end
    end

`ifdef ATTN_SEQ_WDOG_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && start) begin
            err_d = 1'b0;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_attn_seq.sv
// tb/tb_attn_seq.sv - scoreboard bench for attn_seq (NQ=NK=8 and NQ=NK=16 instances)
module tb_attn_seq;

    localparam int BW = 8;
    localparam int PR = 16;
    localparam int DW = PR * BW;
    localparam int KG = 8;

    typedef struct packed {
        logic [16:0]   inst;
        logic [DW-1:0] mem;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          sel;
    logic          in_valid;
    logic          ofifo_valid;
    logic [DW-1:0] in_data;

    logic          start8, start16;
    logic          in_ready8, in_ready16, busy8, busy16, done8, done16, err8, err16;
    logic [16:0]   inst8, inst16;
    logic [DW-1:0] mem8, mem16;

    logic          in_ready_m, busy_m, done_m, err_m;
    logic [16:0]   inst_m;
    logic [DW-1:0] mem_m;

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [DW-1:0] mem_model;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    assign start8     = start && !sel;
    assign start16    = start && sel;
    assign in_ready_m = sel ? in_ready16 : in_ready8;
    assign busy_m     = sel ? busy16 : busy8;
    assign done_m     = sel ? done16 : done8;
    assign err_m      = sel ? err16 : err8;
    assign inst_m     = sel ? inst16 : inst8;
    assign mem_m      = sel ? mem16 : mem8;

    attn_seq #(.BW(BW), .PR(PR), .COL(8), .NQ(8), .NK(8), .KGAP(KG)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .ofifo_valid(ofifo_valid), .inst(inst8), .mem_in(mem8),
        .busy(busy8), .done(done8), .err(err8)
    );

    attn_seq #(.BW(BW), .PR(PR), .COL(8), .NQ(16), .NK(16), .KGAP(KG)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .in_valid(in_valid), .in_ready(in_ready16),
        .in_data(in_data), .ofifo_valid(ofifo_valid), .inst(inst16), .mem_in(mem16),
        .busy(busy16), .done(done16), .err(err16)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [16:0] w, input logic [DW-1:0] m);
        exp_t e;
        e.inst = w;
        e.mem  = m;
        sb_q.push_back(e);
    endtask

    function automatic logic [DW-1:0] vec(input int run, input int ph, input int i);
        logic [7:0] b;
        b = {run[2:0], ph[0], i[3:0]};
        return {16{b}};
    endfunction

    // Every non-zero instruction word must match the next scoreboard entry in order.
    always @(negedge clk) begin
        if (reset === 1'b0 && inst_m != '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_inst", {111'd0, inst_m}, '0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("inst", {111'd0, inst_m}, {111'd0, mon_e.inst});
                chk("mem_in", mem_m, mon_e.mem);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        ofifo_valid = 1'b0;
        #1;
        chk("rst_inst", {111'd0, inst_m}, '0);
        chk("rst_mem_in", mem_m, '0);
        chk("rst_in_ready", in_ready_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_done", done_m, 0);
        chk("rst_err", err_m, 0);
        chk("rst_sb_empty", sb_q.size(), 0);
        sb_q.delete();
        step();
        step();
        reset = 1'b0;
        mem_model = '0;
    endtask

    // fmode: 0 ofifo_valid always high, 1 high one cycle in three, 2 never (watchdog)
    task automatic run(input int nq, input int nk, input int vmode, input int fmode,
                       input int abort_at, input int start_in_exec, input int run_id);
        logic [DW-1:0] last;
        logic [16:0]   w;
        logic          wr_p, rd, v;
        int            n, beat, cyc, rd_n, wr_n, gap_steps;
        last = mem_model;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy_m, 1);
        chk("in_ready_load", in_ready_m, 1);
        chk("err_cleared_by_start", err_m, 0);
        for (int ph = 0; ph < 2; ph++) begin
            n = (ph == 0) ? nq : nk;
            beat = 0;
            cyc = 0;
            while (beat < n) begin
                in_valid = (vmode == 0) || (cyc % 2 == 0);
                if (in_valid) begin
                    in_data = vec(run_id, ph, beat);
                    w = '0;
                    w[(ph == 0) ? 4 : 2] = 1'b1;
                    w[15:12] = beat[3:0];
                    last = in_data;
                    push(w, last);
                    beat++;
                end else begin
                    in_data = ~vec(run_id, ph, beat);
                end
                cyc++;
                step();
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c <= nk; c++) begin
            w = '0;
            w[6] = 1'b1;
            if (c < nk) begin
                w[3] = 1'b1;
                w[15:12] = c[3:0];
            end
            push(w, last);
        end
        for (int c = 0; c <= nq; c++) begin
            w = '0;
            if (c < nq) begin
                w[5] = 1'b1;
                w[15:12] = c[3:0];
            end
            if (c > 0) w[7] = 1'b1;
            push(w, last);
        end
        gap_steps = nk + 1 + KG + nq + 1;
        for (int s = 0; s < gap_steps; s++) begin
            start = (start_in_exec != 0) && (s == nk + 1 + KG + 1);
            ofifo_valid = (fmode == 0) && (s == gap_steps - 1);
            step();
        end
        start = 1'b0;
        if (fmode == 2) begin
            ofifo_valid = 1'b0;
            cyc = 0;
            while (cyc < 200 && done_m !== 1'b1) begin
                step();
                cyc++;
            end
`ifdef ATTN_SEQ_WDOG_EN
            chk("wdog_done", done_m, 1);
            chk("wdog_err", err_m, 1);
            chk("wdog_cycles_in_window", (cyc >= 60 && cyc <= 70), 1);
            step();
            chk("wdog_busy_after", busy_m, 0);
            chk("wdog_err_sticky", err_m, 1);
            mem_model = last;
`else
            chk("nowdog_busy", busy_m, 1);
            chk("nowdog_done", done_m, 0);
            chk("nowdog_err", err_m, 0);
            do_reset();
`endif
            return;
        end
        rd_n = 0;
        wr_n = 0;
        wr_p = 1'b0;
        cyc = 0;
        while (wr_n < nq && cyc < 400) begin
            if (cyc == abort_at) begin
                @(negedge clk);
                #1;
                do_reset();
                return;
            end
            v = (fmode == 0) || (cyc % 3 == 0);
            ofifo_valid = v;
            rd = v && (rd_n < nq);
            w = '0;
            w[16] = rd;
            if (wr_p) begin
                w[0] = 1'b1;
                w[11:8] = wr_n[3:0];
                wr_n++;
            end
            if (w != '0) push(w, last);
            wr_p = rd;
            if (rd) rd_n++;
            cyc++;
            step();
        end
        ofifo_valid = 1'b0;
        chk("drain_rows", wr_n, nq);
        chk("done_pulse", done_m, 1);
        chk("busy_in_done", busy_m, 1);
        step();
        chk("done_low", done_m, 0);
        chk("busy_after_done", busy_m, 0);
        chk("sb_empty", sb_q.size(), 0);
        chk("err_normal", err_m, 0);
        chk("mem_in_hold", mem_m, last);
        mem_model = last;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        sel = 1'b0;
        in_valid = 1'b0;
        ofifo_valid = 1'b0;
        in_data = '0;
        mem_model = '0;
        #2;
        do_reset();
        step();
        run(8, 8, 0, 0, -1, 0, 1);
        run(8, 8, 1, 1, -1, 0, 2);
        run(8, 8, 0, 0, -1, 1, 3);
        run(8, 8, 0, 0, 3, 0, 4);
        run(8, 8, 0, 0, -1, 0, 5);
        sel = 1'b1;
        step();
        run(16, 16, 0, 0, -1, 0, 6);
        run(16, 16, 1, 1, -1, 0, 7);
        sel = 1'b0;
        step();
        run(8, 8, 0, 2, -1, 0, 0);
        run(8, 8, 1, 0, -1, 0, 1);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
